// File: rtl/delta_h_seq.sv
// delta_h_seq: streamed hidden-layer delta = sum(prevd*w) * a*(1-a) in signed fixed point.
// Define DELTA_H_SAT_EN to saturate each WIDTH-bit reduction; otherwise reductions wrap.
module delta_h_seq #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [WIDTH-1:0]         i_a,
    output logic                     o_busy,
    input  logic                     i_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_prevd,
    input  logic [WIDTH-1:0]         i_w,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o,
    output logic [$clog2(NUM+1)-1:0] o_cnt
);
    localparam int CW = $clog2(NUM+1);
    localparam int AW = 2*WIDTH + CW;
    localparam int XW = AW + 2;
    localparam logic signed [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [2:0] {IDLE, ACC, RED, MUL, DONE} state_t;

    state_t                 state_q;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]       a_q, sum_q, deriv_q, o_q, sum_d, deriv_d, o_d;
    logic                   valid_q;
    logic [CW-1:0]          cnt_q;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [XW-1:0]   acc_x, a_x, der_x, s_x, d_x, o_x;

    function automatic logic [WIDTH-1:0] reduce(input logic signed [XW-1:0] x);
`ifdef DELTA_H_SAT_EN
        if (x[XW-1:WIDTH-1] != {(XW-WIDTH+1){x[XW-1]}})
            return x[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return x[WIDTH-1:0];
    endfunction

    // all intermediates are widened so only the final reduction can lose range
    assign prod    = $signed(i_prevd) * $signed(i_w);
    assign acc_d   = acc_q + $signed({{CW{prod[2*WIDTH-1]}}, prod});
    assign acc_x   = $signed({{2{acc_q[AW-1]}}, acc_q}) >>> FRAC;
    assign a_x     = $signed({{(XW-WIDTH){a_q[WIDTH-1]}}, a_q});
    assign der_x   = (a_x * (ONE_X - a_x)) >>> FRAC;
    assign s_x     = $signed({{(XW-WIDTH){sum_q[WIDTH-1]}}, sum_q});
    assign d_x     = $signed({{(XW-WIDTH){deriv_q[WIDTH-1]}}, deriv_q});
    assign o_x     = (s_x * d_x) >>> FRAC;
    assign sum_d   = reduce(acc_x);
    assign deriv_d = reduce(der_x);
    assign o_d     = reduce(o_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            sum_q   <= '0;
            deriv_q <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    a_q     <= i_a;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ACC;
                end
                ACC: if (i_valid) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM-1)) state_q <= RED;
                end
                RED: begin
                    sum_q   <= sum_d;
                    deriv_q <= deriv_d;
                    state_q <= MUL;
                end
                MUL: begin
                    o_q     <= o_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: if (i_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o          = o_q;
    assign o_valid    = valid_q;
    assign o_busy     = state_q != IDLE;
    assign o_in_ready = state_q == ACC;
    assign o_cnt      = cnt_q;
endmodule

// File: tb/tb_delta_h_seq.sv
// tb_delta_h_seq: randomized and directed checks of delta_h_seq against a wide-integer reference model.
module tb_delta_h_seq;
    localparam int NUM = 2;
    localparam int W   = 32;
    localparam int F   = 16;
    localparam int CW  = $clog2(NUM+1);
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (W-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (W-1));

    logic clk = 1'b0;
    logic rst_n, i_start, i_valid, i_ready;
    logic [W-1:0] i_a, i_prevd, i_w, o;
    logic o_busy, o_in_ready, o_valid;
    logic [CW-1:0] o_cnt;
    logic [W-1:0] pd[NUM];
    logic [W-1:0] wt[NUM];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    delta_h_seq #(.NUM(NUM), .WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_a(i_a), .o_busy(o_busy),
        .i_valid(i_valid), .o_in_ready(o_in_ready), .i_prevd(i_prevd), .i_w(i_w),
        .o_valid(o_valid), .i_ready(i_ready), .o(o), .o_cnt(o_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] red(input logic signed [127:0] x);
`ifdef DELTA_H_SAT_EN
        if (x > MAXV) return MAXV[W-1:0];
        if (x < MINV) return MINV[W-1:0];
`endif
        return x[W-1:0];
    endfunction

    task automatic model(input logic [W-1:0] a, output logic [W-1:0] s, output logic [W-1:0] d,
                         output logic [W-1:0] r);
        logic signed [127:0] acc, av, sv, dv;
        acc = 0;
        for (int k = 0; k < NUM; k++) acc = acc + $signed(pd[k]) * $signed(wt[k]);
        av = $signed(a);
        s  = red(acc >>> F);
        d  = red((av * ((128'sd1 <<< F) - av)) >>> F);
        sv = $signed(s);
        dv = $signed(d);
        r  = red((sv * dv) >>> F);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o"}, o, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_inrdy"}, o_in_ready, 0);
        check({tag, "_cnt"}, o_cnt, 0);
    endtask

    task automatic run(input logic [W-1:0] a, input int stall, input int bp);
        logic [W-1:0] es, ed, eo;
        int t, n;
        model(a, es, ed, eo);
        i_start = 1'b1;
        i_a = a;
        tick;
        t = 1;
        i_start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_inrdy", o_in_ready, 1);
        check("start_cnt", o_cnt, 0);
        for (int k = 0; k < NUM; k++) begin
            if (k > 0) begin
                for (int s = 0; s < stall; s++) begin
                    i_valid = 1'b0;
                    i_prevd = $urandom;
                    i_w = $urandom;
                    tick;
                    t++;
                    check("stall_cnt", o_cnt, k);
                end
            end
            i_valid = 1'b1;
            i_prevd = pd[k];
            i_w = wt[k];
            tick;
            t++;
        end
        n = 0;
        while (!o_valid && n < 20) begin
            i_valid = 1'($urandom % 2);
            i_prevd = $urandom;
            i_w = $urandom;
            tick;
            n++;
        end
        i_valid = 1'b0;
        check("lat", n, 2);
        check("start2valid", t + n, NUM + 3 + stall * (NUM - 1));
        check("sum", dut.sum_q, es);
        check("deriv", dut.deriv_q, ed);
        check("o", o, eo);
        check("cnt_final", o_cnt, NUM);
        for (int b = 0; b < bp; b++) begin
            i_start = 1'($urandom % 2);
            i_a = $urandom;
            tick;
            check("bp_valid", o_valid, 1);
            check("bp_o", o, eo);
            check("bp_busy", o_busy, 1);
        end
        i_ready = 1'b1;
        i_start = 1'b1;
        i_a = $urandom;
        tick;
        i_ready = 1'b0;
        i_start = 1'b0;
        check("hs_valid", o_valid, 0);
        check("hs_busy", o_busy, 0);
        check("hs_o_kept", o, eo);
    endtask

    initial begin
        logic [W-1:0] a;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a = '0;
        i_prevd = '0;
        i_w = '0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // nominal, input stalls, output backpressure
        pd[0] = 32'h10000; wt[0] = 32'h8000;
        pd[1] = 32'h20000; wt[1] = 32'h4000;
        run(32'h8000, 0, 0);
        check("t1_o", o, 32'h4000);
        check("t1_sum", dut.sum_q, 32'h10000);
        check("t1_deriv", dut.deriv_q, 32'h4000);
        run(32'h8000, 3, 0);
        check("t2_o", o, 32'h4000);
        run(32'h8000, 0, 5);
        check("t3_o", o, 32'h4000);

        // reset in the middle of accumulation
        i_start = 1'b1;
        i_a = 32'h8000;
        tick;
        i_start = 1'b0;
        i_valid = 1'b1;
        i_prevd = 32'h7FFF0000;
        i_w = 32'h7FFF0000;
        tick;
        i_valid = 1'b0;
        check("mid_cnt", o_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run(32'h8000, 0, 0);
        check("t5_o", o, 32'h4000);

        // saturation / wrap
        pd[0] = 32'h7FFF0000; wt[0] = 32'h7FFF0000;
        pd[1] = 32'h7FFF0000; wt[1] = 32'h7FFF0000;
        run(32'h8000, 0, 1);
`ifdef DELTA_H_SAT_EN
        check("t4_sum", dut.sum_q, 32'h7FFFFFFF);
        check("t4_o", o, 32'h1FFFFFFF);
`endif

        // negative values
        pd[0] = 32'hFFFF0000; wt[0] = 32'h10000;
        pd[1] = 32'h0;        wt[1] = 32'h10000;
        run(32'h4000, 1, 0);
        check("t6_deriv", dut.deriv_q, 32'h3000);
        check("t6_o", o, 32'hFFFFD000);

        for (int r = 0; r < 25; r++) begin
            a = (r % 3 == 0) ? $urandom : $urandom_range(0, 1 << F);
            for (int k = 0; k < NUM; k++) begin
                pd[k] = (r % 2 == 1) ? $urandom : $urandom_range(0, 32'h3FFFF) - 32'h20000;
                wt[k] = (r % 2 == 1) ? $urandom : $urandom_range(0, 32'h3FFFF) - 32'h20000;
            end
            run(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
